// File: rtl/truth_table_checker_if.sv
// Purpose : bundles the checker's stimulus/response and result signals into one port.
// Latency : n/a (signal container only).
// Backpressure : none; start is a level sampled only while the checker is idle or done.
// Ports   : start, y (toward checker); vec, busy, done, pass, err_count,
//           first_fail, fail_valid (from checker).
//           master = checker side, slave = stimulus/observer side.
interface truth_table_checker_if #(
    parameter int N_IN = 3
);
    logic              start;
    logic [N_IN-1:0]   vec;
    logic              y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail;
    logic              fail_valid;

    modport master (
        input  start,
        input  y,
        output vec,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail,
        output fail_valid
    );

    modport slave (
        output start,
        output y,
        input  vec,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail,
        input  fail_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// Purpose : exhaustive truth-table sweep; drives vec 0..2**N_IN-1, samples y, counts mismatches.
// Latency : each vector held SETTLE+1 cycles; done rises 2**N_IN*(SETTLE+1) cycles after start edge.
// Backpressure : none; start is ignored while busy, honoured only in IDLE or DONE.
// Ports   : clk, reset_n (async active-low) plain; everything else through bus (master modport).
module truth_table_checker #(
    parameter int                      N_IN     = 3,
    parameter int                      SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    truth_table_checker_if.master  bus
);

    // Counter only needs to reach SETTLE-1; keep at least one bit.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [N_IN-1:0]  r_vec;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [N_IN:0]    r_err;
    logic [N_IN-1:0]  r_first_fail;
    logic             r_fail_valid;

    logic             w_go;
    logic             w_mis;
    logic             w_last;
    logic [N_IN:0]    w_err_nxt;

    // Mismatch is only acted on in SAMPLE; computing it always is harmless.
    assign w_mis     = bus.y ^ EXPECTED[r_vec];
    assign w_last    = (r_vec == LAST_VEC);
    assign w_err_nxt = r_err + (N_IN+1)'(w_mis);
    assign w_go      = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_APPLY;
            S_APPLY:  if (r_cnt == LAST_CNT) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = w_last ? S_DONE : S_APPLY;
            S_DONE:   if (bus.start) w_state_nxt = S_APPLY;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vec        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
        end else if (w_go) begin
            // Fresh sweep: identical whether coming from IDLE or DONE.
            r_vec        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                S_APPLY: begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_SAMPLE: begin
                    if (w_mis) begin
                        r_err <= w_err_nxt;
                        // Vectors ascend, so the first recorded mismatch is the lowest.
                        if (!r_fail_valid) begin
                            r_first_fail <= r_vec;
                            r_fail_valid <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        // vec stays at the last vector; pass includes this sample.
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_nxt == '0);
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                        r_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.vec        = r_vec;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.first_fail = r_first_fail;
    assign bus.fail_valid = r_fail_valid;

endmodule

// File: tb/tb_truth_table_checker.sv
// Purpose : directed self-checking bench for truth_table_checker (three parameterisations).
// Latency : n/a.
// Backpressure : n/a.
module tb_truth_table_checker;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(3)) ifa ();
    truth_table_checker_if #(.N_IN(3)) ifb ();
    truth_table_checker_if #(.N_IN(3)) ifc ();

    // a: parity reference, SETTLE=1; b: all-ones reference; c: parity, SETTLE=3
    truth_table_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(8'b1001_0110)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.master));
    truth_table_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hFF)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.master));
    truth_table_checker #(.N_IN(3), .SETTLE(3), .EXPECTED(8'b1001_0110)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc.master));

    logic       start_s [3];
    logic       mode_a;      // 0: y = a^b^c, 1: stuck-at-0
    logic       y_c;
    logic [2:0] vec_s   [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic [3:0] err_s   [3];
    logic [2:0] ff_s    [3];
    logic       fv_s    [3];

    assign ifa.start = start_s[0];
    assign ifb.start = start_s[1];
    assign ifc.start = start_s[2];
    assign ifa.y     = mode_a ? 1'b0 : ^ifa.vec;
    assign ifb.y     = (ifb.vec != 3'd6);
    assign ifc.y     = y_c;

    assign vec_s[0] = ifa.vec;  assign vec_s[1] = ifb.vec;  assign vec_s[2] = ifc.vec;
    assign busy_s[0] = ifa.busy; assign busy_s[1] = ifb.busy; assign busy_s[2] = ifc.busy;
    assign done_s[0] = ifa.done; assign done_s[1] = ifb.done; assign done_s[2] = ifc.done;
    assign pass_s[0] = ifa.pass; assign pass_s[1] = ifb.pass; assign pass_s[2] = ifc.pass;
    assign err_s[0] = ifa.err_count; assign err_s[1] = ifb.err_count; assign err_s[2] = ifc.err_count;
    assign ff_s[0] = ifa.first_fail; assign ff_s[1] = ifb.first_fail; assign ff_s[2] = ifc.first_fail;
    assign fv_s[0] = ifa.fail_valid; assign fv_s[1] = ifb.fail_valid; assign fv_s[2] = ifc.fail_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int sel, input string tag);
        chk({tag, "_vec"},  32'(vec_s[sel]),  0);
        chk({tag, "_busy"}, 32'(busy_s[sel]), 0);
        chk({tag, "_done"}, 32'(done_s[sel]), 0);
        chk({tag, "_pass"}, 32'(pass_s[sel]), 0);
        chk({tag, "_err"},  32'(err_s[sel]),  0);
        chk({tag, "_ff"},   32'(ff_s[sel]),   0);
        chk({tag, "_fv"},   32'(fv_s[sel]),   0);
    endtask

    // One full sweep: start at an edge, then verify vec k is held for 'hold'
    // cycles and done rises exactly 8*hold cycles after the start edge.
    // pulse_at >= 0 re-asserts start during that cycle of the sweep.
    task automatic sweep(input int sel, input int hold, input int pulse_at);
        logic [2:0] kv;
        int t;
        @(negedge clk);
        start_s[sel] = 1'b1;
        @(posedge clk);
        t = 0;
        for (int k = 0; k < 8; k++) begin
            kv = k[2:0];
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                start_s[sel] = (t == pulse_at);
                // y is wrong except in the cycle right before the sample edge
                if (sel == 2) y_c = (j == hold - 1) ? ^kv : ~^kv;
                chk($sformatf("s%0d_vec_t%0d", sel, t), 32'(vec_s[sel]), 32'(kv));
                chk($sformatf("s%0d_busy_t%0d", sel, t), 32'(busy_s[sel]), 1);
                chk($sformatf("s%0d_done_t%0d", sel, t), 32'(done_s[sel]), 0);
                if (t == 0) begin
                    chk($sformatf("s%0d_clr_err", sel), 32'(err_s[sel]), 0);
                    chk($sformatf("s%0d_clr_fv", sel), 32'(fv_s[sel]), 0);
                    chk($sformatf("s%0d_clr_pass", sel), 32'(pass_s[sel]), 0);
                end
                t++;
            end
        end
        start_s[sel] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("s%0d_done_edge", sel), 32'(done_s[sel]), 1);
        chk($sformatf("s%0d_busy_end", sel), 32'(busy_s[sel]), 0);
    endtask

    task automatic results(input int sel, input logic exp_pass, input int exp_err,
                           input logic exp_fv, input int exp_ff);
        @(negedge clk);
        chk($sformatf("s%0d_pass", sel), 32'(pass_s[sel]), 32'(exp_pass));
        chk($sformatf("s%0d_err", sel),  32'(err_s[sel]),  32'(exp_err));
        chk($sformatf("s%0d_fv", sel),   32'(fv_s[sel]),   32'(exp_fv));
        if (exp_fv) chk($sformatf("s%0d_ff", sel), 32'(ff_s[sel]), 32'(exp_ff));
        chk($sformatf("s%0d_vec_hold", sel), 32'(vec_s[sel]), 7);
        chk($sformatf("s%0d_done_hold", sel), 32'(done_s[sel]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        mode_a  = 1'b0;
        y_c     = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        chk_zero(2, "rst_c");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stuck-at-0 against parity table: mismatches at 1,2,4,7
        mode_a = 1'b1;
        sweep(0, 2, -1);
        results(0, 1'b0, 4, 1'b1, 1);

        // Restart from DONE with matching model; extra start at cycle 5 is ignored
        mode_a = 1'b0;
        sweep(0, 2, 5);
        results(0, 1'b1, 0, 1'b0, 0);

        // Single fault at vec 6 against all-ones table
        sweep(1, 2, -1);
        results(1, 1'b0, 1, 1'b1, 6);

        // SETTLE=3: y glitches during APPLY, correct only before the sample edge
        sweep(2, 4, -1);
        results(2, 1'b1, 0, 1'b0, 0);

        // Reset mid-sweep at vec=3, away from any clock edge
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (vec_s[0] == 3'd3) seen = 1'b1;
        end
        chk("rst_wait_vec3", 32'(seen), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero(0, "midrst_a");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero(0, "postrst_a");
        sweep(0, 2, -1);
        results(0, 1'b1, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
